// File: rtl/timer_irq_src.sv
// timer_irq_src: memory-mapped down-counting timer that drives one CP0 hwint bit.
// Define TIMER_PRESCALE_EN to add the CTRL[8+PSC_W-1:8] prescaler field.
module timer_irq_src #(
  parameter logic [31:0] PRID_VAL = 32'h17230002,
  parameter int unsigned PSC_W    = 8
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [1:0]  a,
  input  logic        we,
  input  logic [31:0] wdbus,
  output logic [31:0] rd,
  output logic        irq
);
  // state | meaning
  // IDLE  | stopped, waiting for CTRL.EN
  // LOAD  | COUNT <= PRESET
  // CNT   | counting down toward zero
  // INT   | terminal count reached; one-shot stops, auto-reload restarts

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_e;

  if (PSC_W < 1 || PSC_W > 24) begin : g_psc_w_check
    $error("PSC_W must fit inside CTRL[31:8]");
  end

  state_e      state_q, state_d;
  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_pend_q, irq_pend_d;
  logic        wr_ctrl, wr_preset, tick, pend_set, pend_hw_clr;
  logic [31:0] ctrl_rd;
`ifdef TIMER_PRESCALE_EN
  logic [PSC_W-1:0] psc_q, psc_d, pcnt_q, pcnt_d;
`endif

  always_comb begin
    wr_ctrl     = we && (a == 2'd0);
    wr_preset   = we && (a == 2'd1);
    state_d     = state_q;
    en_d        = en_q;
    mode_d      = mode_q;
    im_d        = im_q;
    preset_d    = preset_q;
    count_d     = count_q;
    pend_set    = 1'b0;
    pend_hw_clr = 1'b0;
    tick        = 1'b1;
`ifdef TIMER_PRESCALE_EN
    psc_d  = psc_q;
    pcnt_d = '0;
    tick   = (pcnt_q == psc_q);
    if (state_q == S_CNT && en_q && !tick)
      pcnt_d = pcnt_q + {{(PSC_W-1){1'b0}}, 1'b1};
`endif

    case (state_q)
      S_IDLE: if (en_q) state_d = S_LOAD;
      S_LOAD: begin
        if (en_q) begin
          count_d = preset_q;
          state_d = S_CNT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CNT: begin
        if (!en_q) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (count_q > 32'd1) begin
            count_d = count_q - 32'd1;
          end else begin
            count_d  = 32'd0;
            pend_set = 1'b1;
            state_d  = S_INT;
          end
        end
      end
      S_INT: begin
        if (mode_q == 2'd1) begin
          pend_hw_clr = 1'b1;
          state_d     = S_LOAD;
        end else begin
          en_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Software CTRL writes override the hardware EN clear in INT.
    if (wr_ctrl) begin
      en_d   = wdbus[0];
      mode_d = wdbus[2:1];
      im_d   = wdbus[3];
`ifdef TIMER_PRESCALE_EN
      psc_d  = wdbus[8 +: PSC_W];
`endif
    end
    if (wr_preset) preset_d = wdbus;

    if (pend_set)                                   irq_pend_d = 1'b1;
    else if (wr_ctrl || wr_preset || pend_hw_clr)   irq_pend_d = 1'b0;
    else                                            irq_pend_d = irq_pend_q;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= S_IDLE;
      en_q       <= 1'b0;
      mode_q     <= 2'd0;
      im_q       <= 1'b0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_pend_q <= 1'b0;
`ifdef TIMER_PRESCALE_EN
      psc_q      <= '0;
      pcnt_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      mode_q     <= mode_d;
      im_q       <= im_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_pend_q <= irq_pend_d;
`ifdef TIMER_PRESCALE_EN
      psc_q      <= psc_d;
      pcnt_q     <= pcnt_d;
`endif
    end
  end

  always_comb begin
    ctrl_rd      = 32'd0;
    ctrl_rd[0]   = en_q;
    ctrl_rd[2:1] = mode_q;
    ctrl_rd[3]   = im_q;
`ifdef TIMER_PRESCALE_EN
    ctrl_rd[8 +: PSC_W] = psc_q;
`endif
    case (a)
      2'd0:    rd = ctrl_rd;
      2'd1:    rd = preset_q;
      2'd2:    rd = count_q;
      default: rd = PRID_VAL;
    endcase
  end

  assign irq = irq_pend_q & im_q;

endmodule

// File: tb/tb_timer_irq_src.sv
// Self-checking bench for timer_irq_src: directed scenarios plus randomized
// register traffic compared against a behavioural model of the timer.
module tb_timer_irq_src;
  logic        clk;
  logic        clr_n;
  logic [1:0]  a;
  logic        we;
  logic [31:0] wdbus;
  logic [31:0] rd;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  localparam bit [31:0] PRID = 32'h17230002;

  timer_irq_src dut (
    .clk   (clk),
    .clr_n (clr_n),
    .a     (a),
    .we    (we),
    .wdbus (wdbus),
    .rd    (rd),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural model: phase of the timer plus the software-visible registers.
  localparam int PH_STOPPED = 0, PH_RELOAD = 1, PH_COUNTING = 2, PH_EXPIRED = 3;
  int        m_ph;
  bit        m_en, m_im, m_pend;
  bit [1:0]  m_mode;
  bit [31:0] m_preset, m_count;
  int        m_psc, m_pc;

  task automatic model_reset();
    m_ph = PH_STOPPED; m_en = 0; m_im = 0; m_pend = 0; m_mode = 0;
    m_preset = 0; m_count = 0; m_psc = 0; m_pc = 0;
  endtask

  task automatic model_clock(input bit w, input bit [1:0] ad, input bit [31:0] d);
    int        nph = m_ph;
    bit [31:0] ncount = m_count;
    bit        nen = m_en;
    bit        set_p = 0, hw_clr = 0, tick = 1;
    int        npc = 0;
`ifdef TIMER_PRESCALE_EN
    tick = (m_pc == m_psc);
`endif
    if (m_ph == PH_STOPPED) begin
      if (m_en) nph = PH_RELOAD;
    end else if (m_ph == PH_RELOAD) begin
      if (m_en) begin ncount = m_preset; nph = PH_COUNTING; end
      else nph = PH_STOPPED;
    end else if (m_ph == PH_COUNTING) begin
      if (!m_en) nph = PH_STOPPED;
      else if (!tick) npc = (m_pc + 1) % 256;
      else if (m_count > 1) ncount = m_count - 1;
      else begin ncount = 0; set_p = 1; nph = PH_EXPIRED; end
    end else begin
      if (m_mode == 2'd1) begin hw_clr = 1; nph = PH_RELOAD; end
      else begin nen = 0; nph = PH_STOPPED; end
    end
    if (set_p) m_pend = 1;
    else if ((w && ad <= 2'd1) || hw_clr) m_pend = 0;
    m_ph = nph; m_count = ncount; m_en = nen; m_pc = npc;
    if (w && ad == 2'd0) begin
      m_en = d[0]; m_mode = d[2:1]; m_im = d[3];
`ifdef TIMER_PRESCALE_EN
      m_psc = int'(d[15:8]);
`endif
    end
    if (w && ad == 2'd1) m_preset = d;
  endtask

  function automatic bit [31:0] model_rd(input bit [1:0] s);
    bit [31:0] v;
    case (s)
      2'd0: begin
        v = {28'd0, m_im, m_mode, m_en};
`ifdef TIMER_PRESCALE_EN
        v = v | (32'(m_psc) << 8);
`endif
      end
      2'd1:    v = m_preset;
      2'd2:    v = m_count;
      default: v = PRID;
    endcase
    return v;
  endfunction

  // One clock: drive inputs, let the edge happen, return at the following negedge.
  task automatic step(input bit w, input bit [1:0] ad, input bit [31:0] d);
    we = w; a = ad; wdbus = d;
    @(posedge clk);
    model_clock(w, ad, d);
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic peek(input bit [1:0] s, output bit [31:0] v);
    a = s;
    #1;
    v = rd;
  endtask

  task automatic test_reset();
    bit [31:0] v, exp;
    bit found = 0;
    int n = 0;
    clr_n = 1'b0; we = 1'b0; a = 2'd0; wdbus = 32'd0;
    model_reset();
    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      peek(s[1:0], v);
      exp = (s == 3) ? PRID : 32'd0;
      n_checks++;
      if (v !== exp) begin n_fail++; $display("FAIL reset_rd slot%0d: got %h want %h", s, v, exp); end
    end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
    clr_n = 1'b1;
    step(1, 2'd1, 32'd9);
    step(1, 2'd0, 32'h1);
    while (!found && n < 20) begin
      step(0, 2'd0, 32'd0);
      peek(2'd2, v);
      if (v == 32'd5) found = 1;
      n++;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL reset_reach5: count never read 5, last %0d", v); end
    #2;
    clr_n = 1'b0;
    model_reset();
    peek(2'd2, v);
    n_checks++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL reset_mid_count: got %0d want 0", v); end
    peek(2'd0, v);
    n_checks++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL reset_mid_ctrl: got %h want 0", v); end
    peek(2'd1, v);
    n_checks++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL reset_mid_preset: got %h want 0", v); end
    peek(2'd3, v);
    n_checks++;
    if (v !== PRID) begin n_fail++; $display("FAIL reset_mid_id: got %h want %h", v, PRID); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_mid_irq: got %b want 0", irq); end
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic test_oneshot();
    bit [31:0] v;
    bit [31:0] exp_c[5] = '{0, 3, 2, 1, 0};
    bit        exp_i[5] = '{0, 0, 0, 0, 1};
    step(1, 2'd1, 32'd3);
    step(1, 2'd0, 32'h9);
    for (int k = 0; k < 5; k++) begin
      step(0, 2'd0, 32'd0);
      peek(2'd2, v);
      n_checks++;
      if (v !== exp_c[k]) begin n_fail++; $display("FAIL oneshot_count edge%0d: got %0d want %0d", k+1, v, exp_c[k]); end
      n_checks++;
      if (irq !== exp_i[k]) begin n_fail++; $display("FAIL oneshot_irq edge%0d: got %b want %b", k+1, irq, exp_i[k]); end
    end
    step(0, 2'd0, 32'd0);
    peek(2'd0, v);
    n_checks++;
    if (v !== 32'h8) begin n_fail++; $display("FAIL oneshot_ctrl_en_clr: got %h want 8", v); end
    repeat (2) step(0, 2'd0, 32'd0);
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL oneshot_irq_held: got %b want 1", irq); end
    step(1, 2'd0, 32'h8);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_irq_ack: got %b want 0", irq); end
  endtask

  task automatic test_mask();
    step(1, 2'd1, 32'd2);
    step(1, 2'd0, 32'h1);
    for (int k = 0; k < 6; k++) begin
      step(0, 2'd0, 32'd0);
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL mask_irq edge%0d: got %b want 0", k+1, irq); end
    end
    n_checks++;
    if (dut.irq_pend_q !== 1'b1) begin n_fail++; $display("FAIL mask_pend_set: got %b want 1", dut.irq_pend_q); end
    step(1, 2'd0, 32'h8);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL mask_unmask_irq: got %b want 0", irq); end
    n_checks++;
    if (dut.irq_pend_q !== 1'b0) begin n_fail++; $display("FAIL mask_pend_clr: got %b want 0", dut.irq_pend_q); end
  endtask

  task automatic test_autoreload();
    bit [31:0] v, ec;
    bit        ei;
    step(1, 2'd1, 32'd2);
    step(1, 2'd0, 32'hB);
    for (int k = 1; k <= 13; k++) begin
      step(0, 2'd0, 32'd0);
      ec = (k % 4 == 2) ? 32'd2 : (k % 4 == 3) ? 32'd1 : 32'd0;
      ei = (k % 4 == 0);
      peek(2'd2, v);
      n_checks++;
      if (v !== ec) begin n_fail++; $display("FAIL reload_count edge%0d: got %0d want %0d", k, v, ec); end
      n_checks++;
      if (irq !== ei) begin n_fail++; $display("FAIL reload_irq edge%0d: got %b want %b", k, irq, ei); end
    end
    step(1, 2'd0, 32'd0);
    repeat (2) step(0, 2'd0, 32'd0);
  endtask

  task automatic test_disable();
    bit [31:0] v;
    bit found = 0;
    int n = 0;
    step(1, 2'd1, 32'd10);
    step(1, 2'd0, 32'h9);
    while (!found && n < 30) begin
      step(0, 2'd0, 32'd0);
      peek(2'd2, v);
      if (v == 32'd7) found = 1;
      n++;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL disable_reach7: count never read 7, last %0d", v); end
    // EN drops on the edge that takes COUNT to 6, so 6 is the value that holds.
    step(1, 2'd0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step(0, 2'd0, 32'd0);
      peek(2'd2, v);
      n_checks++;
      if (v !== 32'd6) begin n_fail++; $display("FAIL disable_hold cycle%0d: got %0d want 6", k, v); end
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL disable_irq cycle%0d: got %b want 0", k, irq); end
    end
    step(1, 2'd0, 32'h9);
    step(0, 2'd0, 32'd0);
    step(0, 2'd0, 32'd0);
    peek(2'd2, v);
    n_checks++;
    if (v !== 32'd10) begin n_fail++; $display("FAIL disable_reload: got %0d want 10", v); end
    step(0, 2'd0, 32'd0);
    peek(2'd2, v);
    n_checks++;
    if (v !== 32'd9) begin n_fail++; $display("FAIL disable_recount: got %0d want 9", v); end
    step(1, 2'd0, 32'h0);
    repeat (2) step(0, 2'd0, 32'd0);
  endtask

  task automatic test_preset_zero();
    bit [31:0] v;
    step(1, 2'd1, 32'd0);
    step(1, 2'd0, 32'h9);
    step(0, 2'd0, 32'd0);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL pz_irq edge1: got %b want 0", irq); end
    step(0, 2'd0, 32'd0);
    peek(2'd2, v);
    n_checks++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL pz_count edge2: got %0d want 0", v); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL pz_irq edge2: got %b want 0", irq); end
    step(0, 2'd0, 32'd0);
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL pz_irq edge3: got %b want 1", irq); end
    step(1, 2'd0, 32'h0);
    step(0, 2'd0, 32'd0);
  endtask

  task automatic test_collision();
    bit [31:0] v;
    step(1, 2'd1, 32'd1);
    step(1, 2'd0, 32'h9);
    repeat (3) step(0, 2'd0, 32'd0);
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL coll_in_int: got %b want 1", irq); end
    step(1, 2'd0, 32'h9);
    peek(2'd0, v);
    n_checks++;
    if (v !== 32'h9) begin n_fail++; $display("FAIL coll_sw_wins: got %h want 9", v); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL coll_irq_clr: got %b want 0", irq); end
    step(0, 2'd0, 32'd0);
    step(0, 2'd0, 32'd0);
    peek(2'd2, v);
    n_checks++;
    if (v !== 32'd1) begin n_fail++; $display("FAIL coll_reload: got %0d want 1", v); end
    step(0, 2'd0, 32'd0);
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL coll_second_irq: got %b want 1", irq); end
    step(1, 2'd0, 32'h0);
    step(0, 2'd0, 32'd0);
  endtask

  task automatic test_ignored_writes();
    bit [31:0] v, exp;
    step(1, 2'd1, 32'd5);
    step(1, 2'd2, 32'hDEAD_BEEF);
    peek(2'd2, v);
    n_checks++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL ign_count_write: got %h want 0", v); end
    step(1, 2'd3, 32'h1234_5678);
    peek(2'd3, v);
    n_checks++;
    if (v !== PRID) begin n_fail++; $display("FAIL ign_id_write: got %h want %h", v, PRID); end
    peek(2'd1, v);
    n_checks++;
    if (v !== 32'd5) begin n_fail++; $display("FAIL ign_preset_kept: got %h want 5", v); end
    step(1, 2'd0, 32'hFFFF_FFF6);
    exp = 32'h6;
`ifdef TIMER_PRESCALE_EN
    exp = 32'h0000_FF06;
`endif
    peek(2'd0, v);
    n_checks++;
    if (v !== exp) begin n_fail++; $display("FAIL ign_ctrl_bits: got %h want %h", v, exp); end
    step(1, 2'd0, 32'h0);
    step(0, 2'd0, 32'd0);
  endtask

  task automatic test_random();
    bit [31:0] v, d;
    int r;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      d = $urandom;
      if (r < 6) begin
        d[0]     = ($urandom_range(0, 3) != 0);
        d[15:8]  = 8'($urandom_range(0, 2));
        step(1, 2'd0, d);
      end else if (r < 10) begin
        step(1, 2'd1, 32'($urandom_range(0, 6)));
      end else if (r < 12) begin
        step(1, (r == 10) ? 2'd2 : 2'd3, d);
      end else begin
        step(0, 2'd0, 32'd0);
      end
      for (int s = 0; s < 4; s++) begin
        peek(s[1:0], v);
        n_checks++;
        if (v !== model_rd(s[1:0])) begin
          n_fail++;
          $display("FAIL rand_rd cycle%0d slot%0d: got %h want %h", i, s, v, model_rd(s[1:0]));
        end
      end
      n_checks++;
      if (irq !== (m_pend & m_im)) begin
        n_fail++;
        $display("FAIL rand_irq cycle%0d: got %b want %b", i, irq, m_pend & m_im);
      end
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_mask();
    test_autoreload();
    test_disable();
    test_preset_zero();
    test_collision();
    test_ignored_writes();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
